mig_truth_table_gen: RTL and testbench

- Programmable majority-inverter-graph (MIG) evaluator for the 7-input function classification flow.
- Holds a run-time-loaded netlist of up to NUM_GATES 3-input majority gates with optional input inversion.
- On start, sweeps all 2^NUM_INPUTS input patterns, evaluating one gate per cycle, and assembles the complete truth table.
- Hands the truth table downstream on a valid/ready port, replacing per-function hardwired majority netlists.

---
 rtl/mig_truth_table_gen.sv | 185 ++++++++++++++++++
 tb/tb_mig_truth_table_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_truth_table_gen.sv
// mig_truth_table_gen
// Programmable majority-inverter-graph evaluator. A netlist of up to
// NUM_GATES 3-input majority gates (each operand optionally inverted) is
// loaded while idle. On start the block sweeps every input pattern,
// evaluating one gate per cycle, and assembles the full truth table. The
// finished table is offered on a valid/ready port.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   cfg_we, cfg_gate        write one gate descriptor (IDLE only)
//   cfg_sel_a/b/c, cfg_inv  operand selects and per-operand inversion
//   cfg_out_we              write output descriptor (IDLE only)
//   cfg_out_sel/cfg_out_inv network output select and inversion
//   start                   begin a sweep (IDLE only)
//   busy                    high while evaluating / capturing
//   tt_valid/tt_ready       truth-table handshake
//   tt_data                 bit p = f(pattern p), x[k] = bit k of p
//
// Select encoding: 0 = constant 0, 1..NUM_INPUTS = x[k-1],
// NUM_INPUTS+1+j = gate output w[j], anything larger = constant 0.
module mig_truth_table_gen #(
  parameter int NUM_INPUTS = 7,
  parameter int NUM_GATES  = 8,
  localparam int TT_W   = 1 << NUM_INPUTS,
  localparam int SEL_W  = $clog2(1 + NUM_INPUTS + NUM_GATES),
  localparam int GATE_W = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [GATE_W-1:0] cfg_gate,
  input  logic [SEL_W-1:0]  cfg_sel_a,
  input  logic [SEL_W-1:0]  cfg_sel_b,
  input  logic [SEL_W-1:0]  cfg_sel_c,
  input  logic [2:0]        cfg_inv,
  input  logic              cfg_out_we,
  input  logic [SEL_W-1:0]  cfg_out_sel,
  input  logic              cfg_out_inv,
  input  logic              start,
  output logic              busy,
  output logic              tt_valid,
  input  logic              tt_ready,
  output logic [TT_W-1:0]   tt_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVAL    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_next;

  // Netlist descriptors
  logic [SEL_W-1:0] sel_a [NUM_GATES];
  logic [SEL_W-1:0] sel_b [NUM_GATES];
  logic [SEL_W-1:0] sel_c [NUM_GATES];
  logic [2:0]       inv   [NUM_GATES];
  logic [SEL_W-1:0] out_sel;
  logic             out_inv;

  // Sweep datapath
  logic [NUM_INPUTS-1:0] pat;
  logic [GATE_W-1:0]     g;
  logic [NUM_GATES-1:0]  w;

  logic op_a, op_b, op_c, maj, out_bit;
  logic last_gate, last_pat;

  // Resolve a select against the current pattern and the gate outputs.
  // Only gates with index below lim are visible: in EVAL lim = g, which
  // turns self and forward references into constant 0 and rules out any
  // combinational loop; in CAPTURE every gate is visible.
  function automatic logic resolve(
    input logic [SEL_W-1:0]      sel,
    input logic [NUM_INPUTS-1:0] p,
    input logic [NUM_GATES-1:0]  wv,
    input int unsigned           lim
  );
    int unsigned s;
    logic        r;
    s = 32'(sel);
    r = 1'b0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (s == k + 1) r = p[k];
    end
    for (int unsigned j = 0; j < NUM_GATES; j++) begin
      if (s == NUM_INPUTS + 1 + j && j < lim) r = wv[j];
    end
    return r;
  endfunction

  always_comb begin
    op_a      = resolve(sel_a[g], pat, w, 32'(g)) ^ inv[g][0];
    op_b      = resolve(sel_b[g], pat, w, 32'(g)) ^ inv[g][1];
    op_c      = resolve(sel_c[g], pat, w, 32'(g)) ^ inv[g][2];
    maj       = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
    out_bit   = resolve(out_sel, pat, w, NUM_GATES) ^ out_inv;
    last_gate = (g == GATE_W'(NUM_GATES - 1));
    last_pat  = (pat == '1);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    tt_valid   = 1'b0;
    case (state)
      IDLE:    if (start) state_next = EVAL;
      EVAL: begin
        busy = 1'b1;
        if (last_gate) state_next = CAPTURE;
      end
      CAPTURE: begin
        busy       = 1'b1;
        state_next = last_pat ? DONE : EVAL;
      end
      DONE: begin
        tt_valid = 1'b1;
        if (tt_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Configuration store and sweep datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_GATES; i++) begin
        sel_a[i] <= '0;
        sel_b[i] <= '0;
        sel_c[i] <= '0;
        inv[i]   <= '0;
      end
      out_sel <= '0;
      out_inv <= 1'b0;
      pat     <= '0;
      g       <= '0;
      w       <= '0;
      tt_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_we && (32'(cfg_gate) < NUM_GATES)) begin
            sel_a[cfg_gate] <= cfg_sel_a;
            sel_b[cfg_gate] <= cfg_sel_b;
            sel_c[cfg_gate] <= cfg_sel_c;
            inv[cfg_gate]   <= cfg_inv;
          end
          if (cfg_out_we) begin
            out_sel <= cfg_out_sel;
            out_inv <= cfg_out_inv;
          end
          if (start) begin
            pat     <= '0;
            g       <= '0;
            w       <= '0;
            tt_data <= '0;
          end
        end
        EVAL: begin
          w[g] <= maj;
          g    <= last_gate ? '0 : g + 1'b1;
        end
        CAPTURE: begin
          tt_data[pat] <= out_bit;
          if (!last_pat) begin
            pat <= pat + 1'b1;
            g   <= '0;
            w   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mig_truth_table_gen.sv
module tb_mig_truth_table_gen;

  localparam int NI  = 7;
  localparam int NG  = 8;
  localparam int TTW = 128;
  localparam int LAT = TTW * (NG + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_we;
  logic [2:0]       cfg_gate;
  logic [3:0]       cfg_sel_a, cfg_sel_b, cfg_sel_c;
  logic [2:0]       cfg_inv;
  logic             cfg_out_we;
  logic [3:0]       cfg_out_sel;
  logic             cfg_out_inv;
  logic             start;
  logic             busy;
  logic             tt_valid;
  logic             tt_ready;
  logic [TTW-1:0]   tt_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference netlist
  int   m_a [NG];
  int   m_b [NG];
  int   m_c [NG];
  int   m_inv [NG];
  int   m_os;
  int   m_oi;

  mig_truth_table_gen #(.NUM_INPUTS(NI), .NUM_GATES(NG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_gate   (cfg_gate),
    .cfg_sel_a  (cfg_sel_a),
    .cfg_sel_b  (cfg_sel_b),
    .cfg_sel_c  (cfg_sel_c),
    .cfg_inv    (cfg_inv),
    .cfg_out_we (cfg_out_we),
    .cfg_out_sel(cfg_out_sel),
    .cfg_out_inv(cfg_out_inv),
    .start      (start),
    .busy       (busy),
    .tt_valid   (tt_valid),
    .tt_ready   (tt_ready),
    .tt_data    (tt_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [TTW-1:0] act, input logic [TTW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, req);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NG; i++) begin
      m_a[i] = 0; m_b[i] = 0; m_c[i] = 0; m_inv[i] = 0;
    end
    m_os = 0;
    m_oi = 0;
  endfunction

  // Value of a signal number: 0 const, 1..NI input, then gates that are
  // already computed for this pattern (index below `avail`), else 0.
  function automatic int sig_val(input int s, input int p, input int wv[NG], input int avail);
    if (s >= 1 && s <= NI) return (p >> (s - 1)) & 1;
    if (s > NI && s <= NI + NG && (s - NI - 1) < avail) return wv[s - NI - 1];
    return 0;
  endfunction

  function automatic logic [TTW-1:0] model_tt();
    logic [TTW-1:0] tt;
    int wv[NG];
    int a, b, c, f;
    tt = '0;
    for (int p = 0; p < TTW; p++) begin
      for (int i = 0; i < NG; i++) wv[i] = 0;
      for (int gi = 0; gi < NG; gi++) begin
        a = sig_val(m_a[gi], p, wv, gi) ^ (m_inv[gi] & 1);
        b = sig_val(m_b[gi], p, wv, gi) ^ ((m_inv[gi] >> 1) & 1);
        c = sig_val(m_c[gi], p, wv, gi) ^ ((m_inv[gi] >> 2) & 1);
        wv[gi] = (a + b + c >= 2) ? 1 : 0;
      end
      f = sig_val(m_os, p, wv, NG) ^ m_oi;
      tt[p] = f[0];
    end
    return tt;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_gate(input int gi, input int a, input int b, input int c, input int iv);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_gate  = 3'(gi);
    cfg_sel_a = 4'(a);
    cfg_sel_b = 4'(b);
    cfg_sel_c = 4'(c);
    cfg_inv   = 3'(iv);
    @(negedge clk);
    cfg_we = 1'b0;
    m_a[gi] = a; m_b[gi] = b; m_c[gi] = c; m_inv[gi] = iv;
  endtask

  task automatic set_out(input int s, input int iv);
    @(negedge clk);
    cfg_out_we  = 1'b1;
    cfg_out_sel = 4'(s);
    cfg_out_inv = iv[0];
    @(negedge clk);
    cfg_out_we = 1'b0;
    m_os = s;
    m_oi = iv;
  endtask

  // Pulse start and wait for tt_valid; lat = edges after the accepting edge.
  // With disturb set, issue start and cfg writes a few cycles into EVAL.
  task automatic sweep(input bit disturb, output int lat);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (lat < 3 * LAT) begin
      @(posedge clk);
      lat++;
      #1;
      if (disturb && lat == 3) begin
        start = 1'b1;
        cfg_we = 1'b1; cfg_gate = 3'd0;
        cfg_sel_a = 4'd0; cfg_sel_b = 4'd0; cfg_sel_c = 4'd0; cfg_inv = 3'd7;
        cfg_out_we = 1'b1; cfg_out_sel = 4'd0; cfg_out_inv = 1'b1;
      end
      if (disturb && lat == 5) begin
        start = 1'b0; cfg_we = 1'b0; cfg_out_we = 1'b0;
      end
      if (tt_valid) break;
    end
  endtask

  task automatic accept(input string tag, input logic [TTW-1:0] req);
    @(negedge clk);
    tt_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, {127'b0, tt_valid}, '0);
    check({tag, "_data_kept"}, tt_data, req);
    @(negedge clk);
    tt_ready = 1'b0;
  endtask

  task automatic run_case(input string tag, input bit disturb, input logic [TTW-1:0] req);
    int lat;
    sweep(disturb, lat);
    check({tag, "_lat"}, TTW'(lat), TTW'(LAT));
    check(tag, tt_data, req);
    accept(tag, req);
  endtask

  initial begin
    logic [TTW-1:0] exp;
    logic [TTW-1:0] held;
    int lat;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_gate = '0;
    cfg_sel_a = '0; cfg_sel_b = '0; cfg_sel_c = '0; cfg_inv = '0;
    cfg_out_we = 1'b0; cfg_out_sel = '0; cfg_out_inv = 1'b0;
    start = 1'b0; tt_ready = 1'b0;
    model_clear();
    #12;
    check("rst_busy",  {127'b0, busy},     '0);
    check("rst_valid", {127'b0, tt_valid}, '0);
    check("rst_data",  tt_data,            '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic majority
    set_gate(0, 1, 2, 3, 0);
    set_out(NI + 1, 0);
    check("maj_model", model_tt(), {16{8'hE8}});
    run_case("maj", 1'b0, {16{8'hE8}});

    // Constant output after reset
    do_reset();
    set_out(0, 1);
    run_case("const1", 1'b0, '1);

    // Six-gate chain
    do_reset();
    set_gate(0, 1, 2, 5, 0);
    set_gate(1, 2, 3, 5, 0);
    set_gate(2, 3, 4, NI + 1, 0);
    set_gate(3, 1, 2, 7, 0);
    set_gate(4, 6, NI + 2, NI + 4, 0);
    set_gate(5, 1, NI + 3, NI + 5, 0);
    set_out(NI + 6, 0);
    exp = 128'hfeeaeaaaeee8e880fee8e888aaa8a880;
    check("chain_model", model_tt(), exp);
    run_case("chain", 1'b0, exp);

    // Inversion and forward reference
    do_reset();
    set_gate(0, 1, 2, NI + 4, 1);
    set_out(NI + 1, 0);
    exp = {16{8'h44}};
    sweep(1'b0, lat);
    check("fwd_lat", TTW'(lat), TTW'(LAT));
    check("fwd", tt_data, exp);
    held = tt_data;
    check("fwd_p2", {127'b0, held[2]}, TTW'(1));
    // Back-pressure: hold ready low, a stray start must not matter
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = (i == 5);
      if (i % 5 == 4) begin
        check("bp_valid", {127'b0, tt_valid}, TTW'(1));
        check("bp_data", tt_data, exp);
      end
    end
    start = 1'b0;
    accept("fwd", exp);

    // Frozen netlist: writes and start during EVAL are ignored
    do_reset();
    set_gate(0, 1, 2, 3, 0);
    set_gate(1, NI + 1, 4, 5, 2);
    set_out(NI + 2, 1);
    run_case("frozen", 1'b1, model_tt());

    // Randomized netlists; one run with tt_ready held high from the start
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int gi = 0; gi < NG; gi++)
        set_gate(gi, $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 7));
      set_out($urandom_range(NI + 1, 15), $urandom_range(0, 1));
      if (r == 3) tt_ready = 1'b1;
      run_case($sformatf("rand%0d", r), 1'b0, model_tt());
    end

    // Reset mid-sweep
    do_reset();
    set_gate(0, 1, 2, 3, 0);
    set_out(NI + 1, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (499) @(posedge clk);
    #2;
    check("mid_busy_pre", {127'b0, busy}, TTW'(1));
    rst_n = 1'b0;
    model_clear();
    #1;
    check("mid_busy",  {127'b0, busy},     '0);
    check("mid_valid", {127'b0, tt_valid}, '0);
    check("mid_data",  tt_data,            '0);
    @(negedge clk);
    rst_n = 1'b1;
    set_out(0, 1);
    run_case("post_rst", 1'b0, '1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
